// File: rtl/dispatch_router_pkg.sv
// Shared definitions for the dispatch router: queue class encodings, the default
// queue count and the width rule used by every count handshake.
package dispatch_router_pkg;

    typedef enum logic [1:0] {
        CLS_ALU = 2'd0,
        CLS_MEM = 2'd1,
        CLS_BR  = 2'd2
    } uop_cls_e;

    localparam int NUM_Q_DEF = 3;

    // A count port must be able to express every value from 0 up to depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/dispatch_router_prefix.sv
// Finds the longest in-order prefix of the staging buffer that every destination
// queue can absorb this cycle, plus per-class counts and per-uop output slots.
module dispatch_prefix_calc
    import dispatch_router_pkg::*;
#(
    parameter  int PUSH_WIDTH = 4,
    parameter  int NUM_Q      = NUM_Q_DEF,
    parameter  int CLS_W      = 2,
    localparam int CT_W       = count_width(PUSH_WIDTH)
) (
    input  logic [PUSH_WIDTH*CLS_W-1:0] stage_cls,
    input  logic [CT_W-1:0]             occ,
    input  logic [NUM_Q*CT_W-1:0]       q_ready_ct,
    output logic [CT_W-1:0]             k,
    output logic [NUM_Q*CT_W-1:0]       cls_ct,
    output logic [PUSH_WIDTH*CT_W-1:0]  slot_idx,
    output logic                        bad
);

    logic [CT_W-1:0]  cnt [NUM_Q];
    logic             stop;
    logic             fits;
    logic [CLS_W-1:0] cls;

    // Walk oldest to youngest; the first uop that does not fit ends the prefix, so the
    // greedy walk yields the largest legal k. Bad classes are flagged even past the stop.
    always_comb begin
        k        = '0;
        bad      = 1'b0;
        stop     = 1'b0;
        fits     = 1'b0;
        cls      = '0;
        slot_idx = '0;
        for (int c = 0; c < NUM_Q; c++) begin
            cnt[c] = '0;
        end
        for (int i = 0; i < PUSH_WIDTH; i++) begin
            cls  = stage_cls[i*CLS_W +: CLS_W];
            fits = 1'b0;
            if (CT_W'(i) < occ) begin
                if (int'(cls) >= NUM_Q) begin
                    bad  = 1'b1;
                    stop = 1'b1;
                end else if (!stop) begin
                    for (int c = 0; c < NUM_Q; c++) begin
                        if (int'(cls) == c && cnt[c] < q_ready_ct[c*CT_W +: CT_W]) begin
                            fits = 1'b1;
                        end
                    end
                    if (fits) begin
                        for (int c = 0; c < NUM_Q; c++) begin
                            if (int'(cls) == c) begin
                                slot_idx[i*CT_W +: CT_W] = cnt[c];
                                cnt[c] = cnt[c] + CT_W'(1);
                            end
                        end
                        k = k + CT_W'(1);
                    end else begin
                        stop = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        cls_ct = '0;
        for (int c = 0; c < NUM_Q; c++) begin
            cls_ct[c*CT_W +: CT_W] = cnt[c];
        end
    end

endmodule

// File: rtl/dispatch_router.sv
// In-order dispatch router: stages up to PUSH_WIDTH uops and hands the longest
// acceptable prefix to NUM_Q count-handshaked issue buffers each cycle.
module dispatch_router
    import dispatch_router_pkg::*;
#(
    parameter  int DATA_WIDTH = 47,
    parameter  int PUSH_WIDTH = 4,
    parameter  int NUM_Q      = NUM_Q_DEF,
    parameter  int CLS_W      = 2,
    localparam int CT_W       = count_width(PUSH_WIDTH)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               flush,
    input  logic [PUSH_WIDTH*DATA_WIDTH-1:0]   din,
    input  logic [PUSH_WIDTH*CLS_W-1:0]        din_cls,
    input  logic [CT_W-1:0]                    din_valid_ct,
    output logic [CT_W-1:0]                    din_ready_ct,
    output logic [NUM_Q*PUSH_WIDTH*DATA_WIDTH-1:0] q_din,
    output logic [NUM_Q*CT_W-1:0]              q_valid_ct,
    input  logic [NUM_Q*CT_W-1:0]              q_ready_ct,
    output logic                               bad_cls,
    output logic [15:0]                        stall_cycles
);

    logic [PUSH_WIDTH*DATA_WIDTH-1:0] stage_data;
    logic [PUSH_WIDTH*DATA_WIDTH-1:0] stage_data_nxt;
    logic [PUSH_WIDTH*CLS_W-1:0]      stage_cls;
    logic [PUSH_WIDTH*CLS_W-1:0]      stage_cls_nxt;
    logic [CT_W-1:0]                  occ;
    logic [CT_W-1:0]                  occ_nxt;
    logic [CT_W-1:0]                  k;
    logic [CT_W-1:0]                  k_eff;
    logic [CT_W-1:0]                  n_in;
    logic [CT_W-1:0]                  rem;
    logic [NUM_Q*CT_W-1:0]            cls_ct;
    logic [PUSH_WIDTH*CT_W-1:0]       slot_idx;
    logic                             bad_now;
    logic                             blocked;

    dispatch_prefix_calc #(
        .PUSH_WIDTH (PUSH_WIDTH),
        .NUM_Q      (NUM_Q),
        .CLS_W      (CLS_W)
    ) u_prefix (
        .stage_cls  (stage_cls),
        .occ        (occ),
        .q_ready_ct (q_ready_ct),
        .k          (k),
        .cls_ct     (cls_ct),
        .slot_idx   (slot_idx),
        .bad        (bad_now)
    );

    // Ready is derived from occupancy alone so upstream never sees a path from the queues.
    assign blocked      = rst | flush;
    assign din_ready_ct = blocked ? '0 : CT_W'(PUSH_WIDTH) - occ;
    assign n_in         = (din_valid_ct < din_ready_ct) ? din_valid_ct : din_ready_ct;
    assign k_eff        = blocked ? '0 : k;
    assign rem          = occ - k_eff;
    assign occ_nxt      = rem + n_in;

    always_comb begin
        q_din      = '0;
        q_valid_ct = '0;
        if (!blocked) begin
            for (int c = 0; c < NUM_Q; c++) begin
                q_valid_ct[c*CT_W +: CT_W] = cls_ct[c*CT_W +: CT_W];
                for (int i = 0; i < PUSH_WIDTH; i++) begin
                    if (CT_W'(i) < k && int'(stage_cls[i*CLS_W +: CLS_W]) == c) begin
                        for (int j = 0; j < PUSH_WIDTH; j++) begin
                            if (slot_idx[i*CT_W +: CT_W] == CT_W'(j)) begin
                                q_din[(c*PUSH_WIDTH+j)*DATA_WIDTH +: DATA_WIDTH] =
                                    stage_data[i*DATA_WIDTH +: DATA_WIDTH];
                            end
                        end
                    end
                end
            end
        end
    end

    // Survivors slide down by k; the accepted part of the new group lands right behind them.
    always_comb begin
        stage_data_nxt = stage_data;
        stage_cls_nxt  = stage_cls;
        for (int i = 0; i < PUSH_WIDTH; i++) begin
            for (int s = 0; s < PUSH_WIDTH; s++) begin
                if (s == i + int'(k_eff) && CT_W'(s) < occ) begin
                    stage_data_nxt[i*DATA_WIDTH +: DATA_WIDTH] = stage_data[s*DATA_WIDTH +: DATA_WIDTH];
                    stage_cls_nxt[i*CLS_W +: CLS_W]            = stage_cls[s*CLS_W +: CLS_W];
                end
            end
            for (int j = 0; j < PUSH_WIDTH; j++) begin
                if (CT_W'(j) < n_in && CT_W'(i) == rem + CT_W'(j)) begin
                    stage_data_nxt[i*DATA_WIDTH +: DATA_WIDTH] = din[j*DATA_WIDTH +: DATA_WIDTH];
                    stage_cls_nxt[i*CLS_W +: CLS_W]            = din_cls[j*CLS_W +: CLS_W];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ          <= '0;
            bad_cls      <= 1'b0;
            stall_cycles <= '0;
        end else begin
            bad_cls <= bad_cls | bad_now;
            if (flush) begin
                occ <= '0;
            end else begin
                occ        <= occ_nxt;
                stage_data <= stage_data_nxt;
                stage_cls  <= stage_cls_nxt;
                if (occ != '0 && k == '0 && stall_cycles != 16'hFFFF) begin
                    stall_cycles <= stall_cycles + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dispatch_router.sv
// Directed self-checking bench for dispatch_router with hand-computed expectations
// for reset, routing, partial dispatch, stalls, partial accept, flush and bad classes.
module tb_dispatch_router;
    import dispatch_router_pkg::*;

    localparam int DW  = 47;
    localparam int PW  = 4;
    localparam int NQ  = 3;
    localparam int CTW = 3;

    logic                  clk;
    logic                  rst;
    logic                  flush;
    logic [PW*DW-1:0]      din;
    logic [PW*2-1:0]       din_cls;
    logic [CTW-1:0]        din_valid_ct;
    logic [CTW-1:0]        din_ready_ct;
    logic [NQ*PW*DW-1:0]   q_din;
    logic [NQ*CTW-1:0]     q_valid_ct;
    logic [NQ*CTW-1:0]     q_ready_ct;
    logic                  bad_cls;
    logic [15:0]           stall_cycles;

    int n_vec = 0;
    int n_err = 0;

    dispatch_router #(
        .DATA_WIDTH (DW),
        .PUSH_WIDTH (PW),
        .NUM_Q      (NQ),
        .CLS_W      (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .din          (din),
        .din_cls      (din_cls),
        .din_valid_ct (din_valid_ct),
        .din_ready_ct (din_ready_ct),
        .q_din        (q_din),
        .q_valid_ct   (q_valid_ct),
        .q_ready_ct   (q_ready_ct),
        .bad_cls      (bad_cls),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [CTW-1:0] qv(input int c);
        return q_valid_ct[c*CTW +: CTW];
    endfunction

    function automatic logic [DW-1:0] qd(input int c, input int j);
        return q_din[(c*PW+j)*DW +: DW];
    endfunction

    function automatic logic [DW-1:0] pay(input int n);
        return 47'h2A00_0000_0000 + DW'(n);
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input int valid, input logic [7:0] clsv, input int base);
        for (int i = 0; i < PW; i++) begin
            din[i*DW +: DW] = pay(base + i);
        end
        din_cls      = clsv;
        din_valid_ct = CTW'(valid);
    endtask

    task automatic setReady(input int alu, input int mem, input int br);
        q_ready_ct = {CTW'(br), CTW'(mem), CTW'(alu)};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        din   = '0;
        din_cls = '0;
        din_valid_ct = '0;
        setReady(4, 4, 4);
        applyStimulus(4, 8'b10_00_01_00, 90);

        // Reset: offered group must be refused and nothing presented.
        step();
        step();
        #1;
        checkOutput("rst_ready", din_ready_ct, 0);
        checkOutput("rst_qv_alu", qv(CLS_ALU), 0);
        rst = 1'b0;
        applyStimulus(0, 8'h00, 0);
        #1;
        checkOutput("post_rst_ready", din_ready_ct, 4);
        checkOutput("post_rst_stall", stall_cycles, 0);
        checkOutput("post_rst_bad", bad_cls, 0);

        // Full group {ALU,MEM,ALU,BR}, every queue can take 4.
        step();
        applyStimulus(4, 8'b10_00_01_00, 0);
        #1;
        checkOutput("g1_accept", din_ready_ct, 4);
        step();
        applyStimulus(0, 8'h00, 0);
        #1;
        checkOutput("g1_qv_alu", qv(CLS_ALU), 2);
        checkOutput("g1_qv_mem", qv(CLS_MEM), 1);
        checkOutput("g1_qv_br", qv(CLS_BR), 1);
        checkOutput("g1_alu_s0", qd(CLS_ALU, 0), pay(0));
        checkOutput("g1_alu_s1", qd(CLS_ALU, 1), pay(2));
        checkOutput("g1_alu_s2_zero", qd(CLS_ALU, 2), 0);
        checkOutput("g1_mem_s0", qd(CLS_MEM, 0), pay(1));
        checkOutput("g1_br_s0", qd(CLS_BR, 0), pay(3));
        checkOutput("g1_full_ready", din_ready_ct, 0);
        step();
        checkOutput("g1_drained", din_ready_ct, 4);
        checkOutput("g1_idle_qv", qv(CLS_ALU), 0);

        // Same group with ALU limited to one slot: prefix stops at the second ALU.
        step();
        setReady(1, 4, 4);
        applyStimulus(4, 8'b10_00_01_00, 10);
        step();
        applyStimulus(0, 8'h00, 0);
        #1;
        checkOutput("g2_qv_alu", qv(CLS_ALU), 1);
        checkOutput("g2_qv_mem", qv(CLS_MEM), 1);
        checkOutput("g2_qv_br", qv(CLS_BR), 0);
        checkOutput("g2_alu_s0", qd(CLS_ALU, 0), pay(10));
        checkOutput("g2_mem_s0", qd(CLS_MEM, 0), pay(11));
        step();
        checkOutput("g2_ready2", din_ready_ct, 2);
        checkOutput("g2_rem_alu", qd(CLS_ALU, 0), pay(12));
        checkOutput("g2_rem_br", qd(CLS_BR, 0), pay(13));
        step();
        checkOutput("g2_drained", din_ready_ct, 4);

        // Partial accept then a MEM-headed stall.
        step();
        setReady(0, 0, 0);
        applyStimulus(2, 8'b00_00_00_01, 20);
        step();
        applyStimulus(4, 8'b00_00_10_00, 30);
        #1;
        checkOutput("pa_ready2", din_ready_ct, 2);
        step();
        applyStimulus(0, 8'h00, 0);
        #1;
        checkOutput("pa_full", din_ready_ct, 0);
        checkOutput("stall_1", stall_cycles, 1);
        setReady(4, 0, 4);
        #1;
        checkOutput("mem_head_blocks", qv(CLS_ALU), 0);
        step();
        checkOutput("stall_2", stall_cycles, 2);
        setReady(4, 4, 4);
        #1;
        checkOutput("rel_qv_mem", qv(CLS_MEM), 1);
        checkOutput("rel_qv_alu", qv(CLS_ALU), 2);
        checkOutput("rel_qv_br", qv(CLS_BR), 1);
        checkOutput("rel_mem_s0", qd(CLS_MEM, 0), pay(20));
        checkOutput("rel_alu_s0", qd(CLS_ALU, 0), pay(21));
        checkOutput("rel_alu_s1", qd(CLS_ALU, 1), pay(30));
        checkOutput("rel_br_s0", qd(CLS_BR, 0), pay(31));
        step();
        checkOutput("rel_ready4", din_ready_ct, 4);
        checkOutput("rel_stall_hold", stall_cycles, 2);

        // Flush with three staged uops and a full incoming group.
        step();
        setReady(0, 0, 0);
        applyStimulus(3, 8'b00_01_00_00, 40);
        step();
        setReady(4, 4, 4);
        flush = 1'b1;
        applyStimulus(4, 8'h00, 50);
        #1;
        checkOutput("fl_qv_alu", qv(CLS_ALU), 0);
        checkOutput("fl_qv_mem", qv(CLS_MEM), 0);
        checkOutput("fl_ready", din_ready_ct, 0);
        step();
        flush = 1'b0;
        applyStimulus(0, 8'h00, 0);
        #1;
        checkOutput("fl_after_ready", din_ready_ct, 4);
        checkOutput("fl_after_qv_alu", qv(CLS_ALU), 0);

        // Out-of-range class at stage[1].
        step();
        applyStimulus(2, 8'b00_00_11_00, 60);
        step();
        applyStimulus(0, 8'h00, 0);
        #1;
        checkOutput("bc_qv_alu", qv(CLS_ALU), 1);
        checkOutput("bc_alu_s0", qd(CLS_ALU, 0), pay(60));
        checkOutput("bc_qv_mem", qv(CLS_MEM), 0);
        checkOutput("bc_qv_br", qv(CLS_BR), 0);
        checkOutput("bc_not_yet", bad_cls, 0);
        step();
        checkOutput("bc_set", bad_cls, 1);
        checkOutput("bc_stuck_qv", qv(CLS_ALU), 0);
        checkOutput("bc_ready3", din_ready_ct, 3);
        checkOutput("bc_stall2", stall_cycles, 2);
        step();
        checkOutput("bc_stall3", stall_cycles, 3);
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        checkOutput("bc_sticky", bad_cls, 1);
        checkOutput("bc_flush_ready", din_ready_ct, 4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checkOutput("bc_rst_clear", bad_cls, 0);
        checkOutput("bc_rst_stall", stall_cycles, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
